// File: rtl/fp_add_pipe.sv
// Pipelined floating-point adder/subtractor: operand capture, then unpack/swap, align,
// add/subtract with leading-zero count, and normalize/round/pack into the output register.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);
  localparam int MW  = MAN_W + 4;
  localparam int LZW = $clog2(MW + 1);
  localparam int XW  = EXP_W + 2;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);

  // Handshake: a transfer happens on every rising edge where valid && ready is high. All
  // stage registers move together on advance, and in_ready equals advance.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic             v0, v1, v2, v3;
  logic [W-1:0]     a0, b0;
  logic             sub0;
  logic             s1_sx, s1_eff_sub, s1_xnz, s1_ynz, s1_spec;
  logic [EXP_W-1:0] s1_ex, s1_d;
  logic [MAN_W-1:0] s1_mx, s1_my;
  logic [W-1:0]     s1_spec_res;
  logic [3:0]       s1_spec_flg;
  logic             s2_sx, s2_eff_sub, s2_spec;
  logic [EXP_W-1:0] s2_ex;
  logic [MW-1:0]    s2_mx, s2_my;
  logic [W-1:0]     s2_spec_res;
  logic [3:0]       s2_spec_flg;
  logic             s3_sx, s3_eff_sub, s3_spec;
  logic [EXP_W-1:0] s3_ex;
  logic [MW:0]      s3_sum;
  logic [LZW-1:0]   s3_lzc;
  logic [W-1:0]     s3_spec_res;
  logic [3:0]       s3_spec_flg;

  // Unpack and order by magnitude; denormals collapse to signed zero.
  logic             sa, sb, a_nan, b_nan, a_inf, b_inf, swap, sx;
  logic [EXP_W-1:0] ea, eb, ex, ey;
  logic [MAN_W-1:0] ma, mb, mx, my;
  logic             c1_spec;
  logic [W-1:0]     c1_res;
  logic [3:0]       c1_flg;

  always_comb begin
    sa    = a0[W-1];
    sb    = b0[W-1] ^ sub0;
    ea    = a0[W-2:MAN_W];
    eb    = b0[W-2:MAN_W];
    ma    = (ea == '0) ? '0 : a0[MAN_W-1:0];
    mb    = (eb == '0) ? '0 : b0[MAN_W-1:0];
    a_nan = (&ea) && (|ma);
    b_nan = (&eb) && (|mb);
    a_inf = (&ea) && (ma == '0);
    b_inf = (&eb) && (mb == '0);
    swap  = {eb, mb} > {ea, ma};
    sx    = swap ? sb : sa;
    ex    = swap ? eb : ea;
    ey    = swap ? ea : eb;
    mx    = swap ? mb : ma;
    my    = swap ? ma : mb;
    c1_spec = 1'b0;
    c1_res  = '0;
    c1_flg  = '0;
    if (a_nan || b_nan) begin
      c1_spec = 1'b1;
      c1_res  = QNAN;
    end else if (a_inf && b_inf && (sa != sb)) begin
      c1_spec = 1'b1;
      c1_res  = QNAN;
      c1_flg  = 4'b1000;
    end else if (a_inf || b_inf) begin
      c1_spec = 1'b1;
      c1_res  = {sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // Align: the wide shift keeps every shifted-out bit so it can fold into sticky.
  logic [2*MW-1:0] y_ext;
  logic [31:0]     sh;
  logic [MW-1:0]   c2_my;

  always_comb begin
    sh    = (32'(s1_d) > 32'(MW - 1)) ? 32'(MW - 1) : 32'(s1_d);
    y_ext = {s1_ynz, s1_my, 3'b000, {MW{1'b0}}} >> sh;
    c2_my = {y_ext[2*MW-1:MW+1], y_ext[MW] | (|y_ext[MW-1:0])};
  end

  logic [MW:0]    c3_sum;
  logic [LZW-1:0] c3_lzc;

  always_comb begin
    c3_sum = s2_eff_sub ? ({1'b0, s2_mx} - {1'b0, s2_my}) : ({1'b0, s2_mx} + {1'b0, s2_my});
    c3_lzc = LZW'(MW);
    for (int i = 0; i < MW; i++) begin
      if (c3_sum[i]) c3_lzc = LZW'(MW - 1 - i);
    end
  end

  // Normalize drops the hidden bit: norm holds {mantissa, guard, round, sticky}.
  logic [MW-2:0]          norm;
  logic signed [XW-1:0]   e_norm, e_fin;
  logic [MAN_W:0]         mant_r;
  logic                   g, rs, rup, inexact;
  logic [W-1:0]           c4_res;
  logic [3:0]             c4_flg;

  always_comb begin
    if (s3_sum[MW]) begin
      norm   = {s3_sum[MW-1:2], |s3_sum[1:0]};
      e_norm = XW'(s3_ex) + XW'(1);
    end else begin
      norm   = s3_sum[MW-2:0] << s3_lzc;
      e_norm = XW'(s3_ex) - XW'(s3_lzc);
    end
    g       = norm[2];
    rs      = |norm[1:0];
    inexact = g | rs;
    rup     = g & (rs | norm[3]);
    mant_r  = {1'b0, norm[MW-2:3]} + {{MAN_W{1'b0}}, rup};
    e_fin   = e_norm + XW'(mant_r[MAN_W]);
    c4_res  = '0;
    c4_flg  = '0;
    if (s3_spec) begin
      c4_res = s3_spec_res;
      c4_flg = s3_spec_flg;
    end else if (s3_sum == '0) begin
      c4_res = {s3_eff_sub ? 1'b0 : s3_sx, {(W-1){1'b0}}};
    end else if (e_norm <= 0) begin
      c4_res = {s3_sx, {(W-1){1'b0}}};
      c4_flg = 4'b0011;
    end else if (e_fin >= EMAX) begin
      c4_res = {s3_sx, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      c4_flg = 4'b0101;
    end else begin
      c4_res = {s3_sx, e_fin[EXP_W-1:0], mant_r[MAN_W-1:0]};
      c4_flg = {3'b000, inexact};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else if (advance) begin
      v0        <= in_valid;
      v1        <= v0;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) begin
        result <= c4_res;
        flags  <= c4_flg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      a0          <= op_a;
      b0          <= op_b;
      sub0        <= sub;
      s1_sx       <= sx;
      s1_eff_sub  <= sa ^ sb;
      s1_ex       <= ex;
      s1_d        <= ex - ey;
      s1_mx       <= mx;
      s1_my       <= my;
      s1_xnz      <= (ex != '0);
      s1_ynz      <= (ey != '0);
      s1_spec     <= c1_spec;
      s1_spec_res <= c1_res;
      s1_spec_flg <= c1_flg;
      s2_sx       <= s1_sx;
      s2_eff_sub  <= s1_eff_sub;
      s2_ex       <= s1_ex;
      s2_mx       <= {s1_xnz, s1_mx, 3'b000};
      s2_my       <= c2_my;
      s2_spec     <= s1_spec;
      s2_spec_res <= s1_spec_res;
      s2_spec_flg <= s1_spec_flg;
      s3_sx       <= s2_sx;
      s3_eff_sub  <= s2_eff_sub;
      s3_ex       <= s2_ex;
      s3_sum      <= c3_sum;
      s3_lzc      <= c3_lzc;
      s3_spec     <= s2_spec;
      s3_spec_res <= s2_spec_res;
      s3_spec_flg <= s2_spec_flg;
    end
  end
endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe: directed vectors, random integer-valued sums, back-pressure,
// reset mid-flight, and a half-precision instance.
module tb_fp_add_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  logic        h_in_valid = 1'b0;
  logic        h_in_ready;
  logic [15:0] h_op_a = '0;
  logic [15:0] h_op_b = '0;
  logic        h_sub = 1'b0;
  logic        h_out_valid;
  logic        h_out_ready = 1'b1;
  logic [15:0] h_result;
  logic [3:0]  h_flags;

  fp_add_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  fp_add_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .op_a(h_op_a), .op_b(h_op_b), .sub(h_sub), .out_valid(h_out_valid),
    .out_ready(h_out_ready), .result(h_result), .flags(h_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [35:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_out = 0;
  logic rand_done = 1'b0;

  localparam int NV = 18;
  logic [31:0] t_a [NV] = '{32'h3F800000, 32'h40400000, 32'h3F800000, 32'h3F800000,
                            32'h80000000, 32'h4B800000, 32'h4B800000, 32'h7F800000,
                            32'h7F7FFFFF, 32'h7FC00001, 32'h00800000, 32'hFF800000,
                            32'h00000001, 32'h3F800000, 32'h4B7FFFFF, 32'h4B800000,
                            32'h4B800000, 32'h7F800000};
  logic [31:0] t_b [NV] = '{32'h3F800000, 32'h3F800000, 32'h3F7FFFFF, 32'h3F800000,
                            32'h80000000, 32'h3F800000, 32'h40400000, 32'hFF800000,
                            32'h7F7FFFFF, 32'h3F800000, 32'h00800001, 32'h3F800000,
                            32'h3F800000, 32'hBF800000, 32'h3F000000, 32'h00800000,
                            32'h3F800000, 32'h7F800000};
  logic        t_s [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] t_r [NV] = '{32'h40000000, 32'h40000000, 32'h33800000, 32'h00000000,
                            32'h80000000, 32'h4B800000, 32'h4B800002, 32'h7FC00000,
                            32'h7F800000, 32'h7FC00000, 32'h80000000, 32'hFF800000,
                            32'h3F800000, 32'h40000000, 32'h4B800000, 32'h4B800000,
                            32'h4B7FFFFF, 32'h7FC00000};
  logic [3:0]  t_f [NV] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h8, 4'h5,
                            4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h8};

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Exact single-precision encoding of an integer with magnitude below 2^24.
  function automatic logic [31:0] i2f(input int v);
    logic        s;
    logic [31:0] m;
    int          p;
    if (v == 0) return 32'h0;
    s = (v < 0);
    m = s ? 32'(-v) : 32'(v);
    p = 31;
    while (!m[p]) p--;
    return {s, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  // Called at negedge+1; returns at the following negedge+1.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] r, input logic [3:0] f, output int acc);
    int guard;
    acc = -1;
    in_valid = 1'b1;
    op_a = a;
    op_b = b;
    sub = s;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    if (!in_ready) check("accept_timeout", 36'(in_ready), 36'(1));
    else begin
      exp_q.push_back({f, r});
      acc = cyc + 1;
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk); #1;
      guard++;
    end
    check(tag, 36'(exp_q.size()), 36'(0));
  endtask

  task automatic h_run(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] r, input logic [3:0] f);
    int guard;
    check("h_in_ready", 36'(h_in_ready), 36'(1));
    h_in_valid = 1'b1;
    h_op_a = a;
    h_op_b = b;
    @(negedge clk); #1;
    h_in_valid = 1'b0;
    guard = 0;
    while (!h_out_valid && guard < 10) begin
      @(negedge clk); #1;
      guard++;
    end
    check("h_valid", 36'(h_out_valid), 36'(1));
    check("h_result", {16'h0, h_flags, h_result}, {16'h0, f, r});
    @(negedge clk); #1;
  endtask

  initial begin : monitor
    logic [35:0] held;
    logic [35:0] want;
    logic        have_held;
    have_held = 1'b0;
    held = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) have_held = 1'b0;
      else begin
        if (have_held) check("hold_stable", {flags, result}, held);
        if (out_valid && !out_ready) check("in_ready_stall", 36'(in_ready), 36'(0));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("spurious_out", 36'(out_valid), 36'(0));
          else begin
            want = exp_q.pop_front();
            n_out++;
            check($sformatf("result_%0d", n_out), {flags, result}, want);
          end
        end
        have_held = out_valid && !out_ready;
        held = {flags, result};
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc, va, vb, vr, guard;
    logic rs;

    repeat (3) @(negedge clk);
    #1;
    check("reset_out_valid", 36'(out_valid), 36'(0));
    check("reset_result", {flags, result}, 36'(0));
    check("reset_h_out_valid", 36'(h_out_valid), 36'(0));
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("reset_in_ready", 36'(in_ready), 36'(1));

    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0, acc);
    guard = 0;
    while (!out_valid && guard < 10) begin
      @(negedge clk); #1;
      guard++;
    end
    check("latency", 36'(cyc - acc), 36'(4));
    drain("drain_latency");

    fork
      begin
        for (int i = 0; i < NV; i++) send(t_a[i], t_b[i], t_s[i], t_r[i], t_f[i], acc);
      end
      begin
        repeat (7) @(negedge clk);
        out_ready = 1'b0;
        #1;
        if (out_valid) check("bp_in_ready", 36'(in_ready), 36'(0));
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain("drain_directed");

    fork
      begin
        for (int i = 0; i < 40; i++) begin
          va = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4194304)) : int'($urandom_range(0, 63));
          vb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4194304)) : int'($urandom_range(0, 63));
          if ($urandom_range(0, 1) != 0) va = -va;
          if ($urandom_range(0, 1) != 0) vb = -vb;
          rs = 1'($urandom_range(0, 1));
          vr = rs ? va - vb : va + vb;
          send(i2f(va), i2f(vb), rs, i2f(vr), 4'h0, acc);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_random");

    for (int i = 0; i < 5; i++) send(t_a[i], t_b[i], t_s[i], t_r[i], t_f[i], acc);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 36'(out_valid), 36'(0));
    check("midreset_result", {flags, result}, 36'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("post_reset_in_ready", 36'(in_ready), 36'(1));
    send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0, acc);
    drain("drain_post_reset");

    h_run(16'h3C00, 16'h3C00, 16'h4000, 4'h0);
    h_run(16'h7BFF, 16'h7BFF, 16'h7C00, 4'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, four-stage pipelined IEEE-754 style floating-point adder/subtractor with a valid/ready handshake. It is the successor to the fixed single-precision adder. It adds:
- exponent/mantissa width parameters
- a per-operation subtract mode
- round-to-nearest-even
- full special-value handling
- exception flags
- back-pressure

It sits between the operand-issue logic and any result consumer in the FP datapath.

## Interface
Parameters:
- EXP_W, 8, exponent width (≥4)
- MAN_W, 23, stored mantissa width excluding hidden bit (≥4)
- W, 1+EXP_W+MAN_W, derived operand width (not overridable)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  pipeline accepts operand pair this cycle
- op_a  in  W  operand A
- op_b  in  W  operand B
- sub  in  1  1: compute A−B; 0: compute A+B
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- result  out  W  packed sum
- flags  out  4  [3] invalid, [2] overflow, [1] underflow, [0] inexact

## Operation
- **Effective B:** sign of B is XORed with `sub` before any processing.
- **Denormal inputs:** inputs with exponent 0 are treated as signed zero; the mantissa is ignored.
- **S1, unpack/swap:**
  - Order operands by magnitude ({exp,man} unsigned compare); the larger is X.
  - Effective operation = sign_X XOR sign_Y.
  - d = exp_X − exp_Y.
  - Classify NaN/Inf/zero.
- **S2, align:**
  - Form {1,man} for nonzero operands.
  - Right-shift Y by d, saturating at MAN_W+3.
  - Keep guard and round bits; all shifted-out bits are ORed into sticky.
- **S3, add/sub:**
  - Compute (MAN_W+5)-bit add or subtract of X and the aligned Y.
  - Count leading zeros of the result.
- **S4, normalize/round/pack:**
  - Carry-out: shift right 1, exponent+1, old LSB folds into sticky.
  - Otherwise shift left by LZC, exponent−LZC.
  - Round to nearest, ties to even.
  - A mantissa carry from rounding increments the exponent.
- **Special cases** (priority order):
  1. Any NaN input → canonical qNaN {0, all-ones exp, 1, zeros}, no flags, unless it is Inf−Inf.
  2. +Inf + −Inf → qNaN, invalid=1.
  3. Inf ± finite → that Inf.
  4. Exact zero from x−x → +0.
  5. −0 + −0 → −0.
- **Overflow:** biased exponent ≥ all-ones after rounding → signed Inf; overflow=1, inexact=1.
- **Underflow:** normalized exponent ≤0 → signed zero (flush); underflow=1, inexact=1.
- **Inexact:** set when any of guard/round/sticky is nonzero before rounding.

## Timing
- **Reset:** all stage valid bits 0, out_valid=0, result=0, flags=0. in_ready=1 from the first cycle after release.
- **Latency:** 4 cycles. A pair accepted at edge N gives out_valid=1 after edge N+4, provided no stall occurs.
- **Throughput:** one op per cycle while out_ready=1.
- **Stall rule:** advance = !out_valid || out_ready, and in_ready = advance.
  - When advance=0, every stage register (data and valid) holds.
  - result and flags stay stable while out_valid=1 && out_ready=0.
- **Acceptance:** an input is accepted only on a cycle where in_valid && in_ready.
- **Bubbles:** bubbles propagate as valid=0. Bubbles are not collapsed except at the output, which the advance rule handles.
- **Ordering:** results leave in acceptance order; none is dropped or duplicated.
- **Reset mid-operation:** rst_n low immediately clears all valid bits and outputs. In-flight ops are discarded and none emerges after release.
- **Reset timing:** no output depends combinationally on op_a/op_b. in_ready depends combinationally on out_ready and out_valid only.

## Test plan
- **Basic add, default params:** 0x3F800000 + 0x3F800000, sub=0 → result 0x40000000, flags 0, out_valid exactly 4 cycles after accept. Also 0x40400000 − 0x3F800000 (sub=1) → 0x40000000.
- **Cancellation and zero:**
  - 0x3F800000 − 0x3F7FFFFF → 0x33800000, flags 0.
  - 0x3F800000 − 0x3F800000 → 0x00000000.
  - 0x80000000 + 0x80000000 → 0x80000000.
- **Rounding ties:**
  - 0x4B800000 + 0x3F800000 → 0x4B800000, inexact=1.
  - 0x4B800000 + 0x40400000 → 0x4B800002, inexact=1.
- **Specials:**
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x7FC00001 + 0x3F800000 → 0x7FC00000.
- **Back-pressure:**
  - Stream 8 back-to-back ops, then drop out_ready for 3 cycles mid-stream.
  - Required: in_ready low during the stall, result held stable, all 8 results correct and in order.
- **Reset and parameters:**
  - Pulse rst_n low with 3 ops in flight → out_valid=0 at once and no stale result afterwards.
  - With EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000, and 0x7BFF + 0x7BFF → 0x7C00 with overflow=1.
